// File: rtl/common_pkg.sv
// Shared pipeline types: memory-stage FSM states, load/store size codes, execute control bundle.
package common_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] mem_funct3;
   } control_t;

   // Size code 2'b11 is not a legal access; it is treated as a word.
   function automatic logic [3:0] mem_byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load extraction: picks byte/half/word at the byte offset and sign/zero-extends.
// Purely combinational, no latency, no flow control.
module load_align
   import common_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [31:0] w_shift;

   assign w_shift = i_rdata >> {i_off, 3'b000};

   always_comb begin
      o_data = i_rdata;
      case (i_funct3)
         MEM_B:   o_data = {{24{w_shift[7]}}, w_shift[7:0]};
         MEM_BU:  o_data = {24'h000000, w_shift[7:0]};
         MEM_H:   o_data = {{16{w_shift[15]}}, w_shift[15:0]};
         MEM_HU:  o_data = {16'h0000, w_shift[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: ALU passthrough in 1 cycle, loads/stores min 2 cycles (+1 per dmem wait); stall holds upstream while busy.
// Optional MEM_ALIGN_CHECK_EN flags misaligned half/word accesses instead of silently aligning them.
module memory_stage
   import common_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] alu_res,
   input  logic [31:0] mem_data,
   input  control_t    control,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        misaligned
);

   mem_state_t  r_state;
   mem_state_t  w_next;
   logic        w_stall;
   logic        w_memop;
   logic        w_trap;
   logic        w_accept;
   logic [1:0]  w_size;
   logic [1:0]  w_off;
   logic [31:0] w_wdata;
   logic [31:0] w_load;

   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [31:0] r_alu;
   logic        r_wb_valid;
   logic [31:0] r_wb_data;
   logic        r_misaligned;

   assign w_memop = control.mem_read | control.mem_write;
   assign w_size  = control.mem_funct3[1:0];

`ifdef MEM_ALIGN_CHECK_EN
   logic w_misal;
   assign w_misal = ((w_size == 2'b01) & alu_res[0]) | (w_size[1] & (alu_res[1:0] != 2'b00));
   assign w_trap  = valid_in & w_memop & w_misal;
   assign w_off   = alu_res[1:0];
`else
   assign w_trap  = 1'b0;
   assign w_off   = w_size[1] ? 2'b00 : (w_size[0] ? {alu_res[1], 1'b0} : alu_res[1:0]);
`endif

   assign w_accept = (r_state == IDLE) & valid_in & w_memop & ~w_trap;

   always_comb begin
      w_wdata = mem_data;
      case (w_size)
         2'b00:   w_wdata = {4{mem_data[7:0]}};
         2'b01:   w_wdata = {2{mem_data[15:0]}};
         default: w_wdata = mem_data;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next  = BUSY;
               w_stall = 1'b1;
            end
         end
         BUSY: begin
            if (dmem_ready) w_next  = IDLE;
            else            w_stall = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   load_align u_load_align (
      .i_rdata  (dmem_rdata),
      .i_off    (r_off),
      .i_funct3 (r_funct3),
      .o_data   (w_load)
   );

   // Request fields are captured once on acceptance and stay frozen through BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_funct3 <= '0;
         r_off    <= '0;
         r_alu    <= '0;
      end else if (w_accept) begin
         r_we     <= control.mem_write;
         r_addr   <= {alu_res[31:2], 2'b00};
         r_wdata  <= w_wdata;
         r_be     <= mem_byte_en(w_size, w_off);
         r_funct3 <= control.mem_funct3;
         r_off    <= w_off;
         r_alu    <= alu_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid   <= 1'b0;
         r_wb_data    <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_wb_valid   <= 1'b0;
         r_misaligned <= (r_state == IDLE) & w_trap;
         if ((r_state == IDLE) && valid_in && !w_memop) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= alu_res;
         end else if ((r_state == BUSY) && dmem_ready) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= r_we ? r_alu : w_load;
         end
      end
   end

   assign dmem_req   = (r_state == BUSY);
   assign dmem_we    = dmem_req & r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign dmem_be    = r_be;
   assign stall      = w_stall;
   assign wb_valid   = r_wb_valid;
   assign wb_data    = r_wb_data;
   assign misaligned = r_misaligned;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port valid_in, input, 1, an instruction from execute is present.
REQ-004 SHALL have port alu_res, input, 32, address or ALU result from execute.
REQ-005 SHALL have port mem_data, input, 32, store data (already forwarded).
REQ-006 SHALL have port control, input, control_t, using fields mem_read, mem_write, mem_funct3[2:0].
REQ-007 SHALL have port dmem_req/dmem_we, output, 1 each, memory request and write strobe.
REQ-008 SHALL have port dmem_addr/dmem_wdata, output, 32 each, word-aligned address and lane-replicated data.
REQ-009 SHALL have port dmem_be, output, 4, byte enables.
REQ-010 SHALL have ports dmem_rdata (input, 32) and dmem_ready (input, 1), read data and completion.
REQ-011 SHALL have port stall, output, 1, upstream holds all inputs while high.
REQ-012 SHALL have ports wb_valid (output, 1), wb_data (output, 32) and misaligned (output, 1), registered result to writeback.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 SHALL, in IDLE with valid_in and no memory op, register wb_data=alu_res and wb_valid=1 next cycle, with no stall.
REQ-015 SHALL, in IDLE with valid_in and mem_read or mem_write, latch addr/wdata/be/we/funct3/alu_res[1:0], assert stall, and go to BUSY.
REQ-016 SHALL, in BUSY, hold dmem_req=1 and all dmem_* outputs stable until dmem_ready; dmem_req is 0 in IDLE.
REQ-017 SHALL set stall = (IDLE & valid_in & memop) | (BUSY & !dmem_ready).
REQ-018 SHALL, in BUSY on dmem_ready, return to IDLE and register wb_valid=1 next cycle; BUSY never accepts new input.
REQ-019 SHALL make minimum memory-op latency 2 cycles, input to wb_valid; each extra wait cycle adds one.
REQ-020 SHALL, for loads, set wb_data to the selected byte/half/word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 SHALL, for stores, set wb_data=alu_res; byte/half data replicated across lanes, be=0001<<a[1:0] for byte, 0011<<a[1:0] for half, 1111 for word.
REQ-022 SHALL ignore dmem_ready in IDLE.
REQ-023 SHALL hold wb_valid for exactly one cycle per instruction.

Reset
REQ-024 SHALL, on rst, immediately force state IDLE and drive dmem_req, dmem_we, wb_valid, misaligned, stall-internal regs, and all data regs to 0, including mid-transaction; the aborted access yields no wb_valid.

Configuration
REQ-025 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a half at a[0]=1 or a word at a[1:0]!=0 as misaligned: no dmem_req, no stall, misaligned=1 and wb_valid=0 next cycle for one cycle.
REQ-026 SHALL, without MEM_ALIGN_CHECK_EN, tie misaligned to 0 and force offending low address bits to 0 (half: a[0]; word: a[1:0]).

Structure
REQ-027 SHALL place mem_state_t and the funct3 constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) in common_pkg, and add the mem_read, mem_write and mem_funct3 fields to control_t.
REQ-028 SHALL put load extraction/extension in combinational sub-module load_align.

Verification
REQ-029 SHALL cover ALU passthrough: alu_res=0x1234, no memop -> next cycle wb_valid=1, wb_data=0x1234, stall=0.
REQ-030 SHALL cover LB with ready after 3 cycles: alu_res=0x103, rdata=0x80AABBCC -> dmem_addr=0x100, stall for 4 cycles, wb_data=0xFFFFFF80.
REQ-031 SHALL cover SH with zero-wait ready: alu_res=0x202, mem_data=0xBEEF -> be=1100, wdata=0xBEEFBEEF, we=1, wb_valid after 2 cycles.
REQ-032 SHALL cover LHU with zero-wait: a=0x2, rdata=0x8001xxxx -> wb_data=0x00008001.
REQ-033 SHALL cover rst asserted while BUSY -> dmem_req drops same cycle, no wb_valid, state IDLE.
REQ-034 SHALL cover LW at 0x101 with MEM_ALIGN_CHECK_EN -> no dmem_req, misaligned=1 one cycle; without the macro -> dmem_addr=0x100, normal load.
